// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port (fetch/data) arbiter in front of a single-port RAM with registered read data.
// Define RAM_ARB_RR_EN for round-robin arbitration; otherwise the data port wins, with a fetch starvation guard.
module ram_arbiter #(
   parameter int ADDR_WORDS = 128,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic [31:0] ram_addr,
   output logic        ram_we,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata,
   output logic        err
);
   typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} own_e;
   own_e own_q, own_d;
   logic oor_q, oor_d;
   logic if_oor, d_oor, if_win;
   assign if_oor = if_addr >= 32'(ADDR_WORDS);
   assign d_oor  = d_addr >= 32'(ADDR_WORDS);
`ifdef RAM_ARB_RR_EN
   logic ptr_q, ptr_d;
   assign if_win = ptr_q;
   always_comb ptr_d = (if_req && d_req) ? ~ptr_q : ptr_q;
   always_ff @(posedge clk) ptr_q <= rst ? 1'b0 : ptr_d;
`else
   localparam int WW = $clog2(STARVE_MAX + 2);
   logic [WW-1:0] wait_q, wait_d;
   assign if_win = wait_q == WW'(STARVE_MAX);
   // A withdrawn fetch request leaves no residue in the starvation count.
   always_comb wait_d = (if_gnt || !if_req) ? '0 : wait_q + 1'b1;
   always_ff @(posedge clk) wait_q <= rst ? '0 : wait_d;
`endif
   assign if_gnt    = !rst && if_req && (!d_req || if_win);
   assign d_gnt     = !rst && d_req && !if_gnt;
   assign ram_addr  = if_gnt ? if_addr : d_gnt ? d_addr : '0;
   assign ram_we    = d_gnt && d_we && !d_oor;
   assign ram_wdata = d_gnt ? d_wdata : '0;
   assign err       = (if_gnt && if_oor) || (d_gnt && d_oor);
   always_comb begin
      own_d = if_gnt ? OWN_IF : (d_gnt && !d_we) ? OWN_D : OWN_NONE;
      oor_d = if_gnt ? if_oor : d_oor;
   end
   always_ff @(posedge clk) begin
      own_q <= rst ? OWN_NONE : own_d;
      oor_q <= rst ? 1'b0 : oor_d;
   end
   assign if_rvalid = !rst && own_q == OWN_IF;
   assign d_rvalid  = !rst && own_q == OWN_D;
   assign if_rdata  = (if_rvalid && !oor_q) ? ram_rdata : '0;
   assign d_rdata   = (d_rvalid && !oor_q) ? ram_rdata : '0;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks of ram_arbiter against a behavioural registered-read RAM.
module tb_ram_arbiter;
   logic        clk, rst;
   logic        if_req, if_gnt, if_rvalid;
   logic [31:0] if_addr, if_rdata;
   logic        d_req, d_we, d_gnt, d_rvalid;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic [31:0] ram_addr, ram_wdata, ram_rdata;
   logic        ram_we, err;
   logic [31:0] mem [0:127];
   int n_tests = 0, n_fail = 0;
   ram_arbiter dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .err(err)
   );
   initial clk = 0;
   always #5 clk = ~clk;
   always @(posedge clk) begin
      if (ram_we && ram_addr < 128) mem[ram_addr[6:0]] <= ram_wdata;
      ram_rdata <= (ram_addr < 128) ? mem[ram_addr[6:0]] : 32'hBAD0BAD0;
   end
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask
   task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                        input logic [31:0] da, input logic [31:0] dd);
      @(negedge clk);
      if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
      #1;
   endtask
   task automatic chk_quiet(input string tag);
      chk({tag, "_gnt"}, {30'd0, if_gnt, d_gnt}, 32'd0);
      chk({tag, "_rv"}, {30'd0, if_rvalid, d_rvalid}, 32'd0);
      chk({tag, "_we_err"}, {30'd0, ram_we, err}, 32'd0);
      chk({tag, "_addr"}, ram_addr, 32'd0);
      chk({tag, "_rdata"}, if_rdata | d_rdata, 32'd0);
   endtask
   logic [5:0] exp_if;
   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 32'h0;
      mem[5] = 32'hDEADBEEF;
      rst = 1;
      drive(1, 32'd5, 1, 0, 32'd10, 32'd0);
      drive(1, 32'd5, 1, 1, 32'd10, 32'd7);
      chk_quiet("reset");
      rst = 0;
      // single fetch read
      drive(1, 32'd5, 0, 0, 32'd0, 32'd0);
      chk("fetch_gnt", {30'd0, if_gnt, d_gnt}, 32'd2);
      chk("fetch_addr", ram_addr, 32'd5);
      drive(0, 32'd0, 0, 0, 32'd0, 32'd0);
      chk("fetch_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd2);
      chk("fetch_rdata", if_rdata, 32'hDEADBEEF);
      drive(0, 32'd0, 0, 0, 32'd0, 32'd0);
      chk_quiet("idle");
      // data write then read
      drive(0, 32'd0, 1, 1, 32'd10, 32'h12345678);
      chk("wr_gnt", {30'd0, if_gnt, d_gnt}, 32'd1);
      chk("wr_we", {31'd0, ram_we}, 32'd1);
      chk("wr_wdata", ram_wdata, 32'h12345678);
      drive(0, 32'd0, 1, 0, 32'd10, 32'd0);
      chk("wr_no_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
      chk("rd_gnt_we", {30'd0, d_gnt, ram_we}, 32'd2);
      drive(0, 32'd0, 0, 0, 32'd0, 32'd0);
      chk("rd_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd1);
      chk("rd_rdata", d_rdata, 32'h12345678);
      // contention: grant pattern, with each previous read's rvalid coinciding with the next grant
`ifdef RAM_ARB_RR_EN
      exp_if = 6'b101010;
`else
      exp_if = 6'b010000;
`endif
      for (int i = 0; i < 6; i++) begin
         drive(1, 32'd5, 1, 0, 32'd10, 32'd0);
         chk($sformatf("cont_gnt%0d", i), {30'd0, if_gnt, d_gnt}, exp_if[i] ? 32'd2 : 32'd1);
         if (i > 0) begin
            chk($sformatf("cont_rv%0d", i), {30'd0, if_rvalid, d_rvalid}, exp_if[i-1] ? 32'd2 : 32'd1);
            chk($sformatf("cont_rd%0d", i), if_rdata | d_rdata, exp_if[i-1] ? 32'hDEADBEEF : 32'h12345678);
         end
      end
      drive(0, 32'd0, 0, 0, 32'd0, 32'd0);
      chk("cont_last_rv", {30'd0, if_rvalid, d_rvalid}, exp_if[5] ? 32'd2 : 32'd1);
      // out-of-range write then read
      drive(0, 32'd0, 1, 1, 32'd200, 32'hCAFEF00D);
      chk("oor_wr_gnt", {30'd0, if_gnt, d_gnt}, 32'd1);
      chk("oor_wr_we_err", {30'd0, ram_we, err}, 32'd1);
      drive(1, 32'd128, 0, 0, 32'd0, 32'd0);
      chk("oor_rd_gnt", {30'd0, if_gnt, d_gnt}, 32'd2);
      chk("oor_rd_we_err", {30'd0, ram_we, err}, 32'd1);
      chk("oor_wr_no_rv", {30'd0, if_rvalid, d_rvalid}, 32'd0);
      drive(0, 32'd0, 0, 0, 32'd0, 32'd0);
      chk("oor_rd_rv", {30'd0, if_rvalid, d_rvalid}, 32'd2);
      chk("oor_rd_rdata", if_rdata, 32'd0);
      chk("oor_err_done", {31'd0, err}, 32'd0);
      // reset mid-read
      drive(1, 32'd5, 0, 0, 32'd0, 32'd0);
      chk("rst_rd_gnt", {30'd0, if_gnt, d_gnt}, 32'd2);
      @(negedge clk);
      rst = 1;
      #1;
      chk_quiet("rst_mid");
      drive(0, 32'd0, 0, 0, 32'd0, 32'd0);
      rst = 0;
      #1;
      chk_quiet("rst_after");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
